// File: rtl/cpu_types_pkg.sv
// Shared CPU types: branch-predictor counters, BTB entry layout and counter helpers.
package cpu_types_pkg;

  typedef logic [1:0] bp_cnt_t;

  localparam bp_cnt_t SNT = 2'b00;
  localparam bp_cnt_t WNT = 2'b01;
  localparam bp_cnt_t WT  = 2'b10;
  localparam bp_cnt_t ST  = 2'b11;

  // Tag field is sized for the smallest BTB (4 entries); larger BTBs store zero-extended tags.
  localparam int TAG_W_MAX = 28;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W_MAX-1:0] tag;
    logic [31:0]          target;
    bp_cnt_t              cnt;
  } btb_entry_t;

  function automatic bp_cnt_t cnt_step(input bp_cnt_t cnt, input logic taken);
    if (taken) return (cnt == ST)  ? ST  : bp_cnt_t'(cnt + 2'd1);
    else       return (cnt == SNT) ? SNT : bp_cnt_t'(cnt - 2'd1);
  endfunction

  function automatic logic predict_taken(input bp_cnt_t cnt);
    return cnt >= WT;
  endfunction

endpackage

// File: rtl/fetch_predict_unit_if.sv
// Fetch-stage bundle: icache request, IF/ID outputs and branch-resolution feedback.
interface fetch_predict_unit_if;
  logic        ihit;
  logic        stall;
  logic        halt;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] inst_pc_if;
  logic [31:0] pcp4_in;
  logic [31:0] predicted_pc_in;
  logic        if_id_enable;
  logic        if_id_flush;

  // master: the fetch unit itself; slave: icache, hazard unit, resolution stage and IF/ID.
  modport master (
    input  ihit, stall, halt, redirect, redirect_pc,
           upd_valid, upd_pc, upd_target, upd_taken,
    output imemREN, imemaddr, inst_pc_if, pcp4_in, predicted_pc_in,
           if_id_enable, if_id_flush
  );

  modport slave (
    output ihit, stall, halt, redirect, redirect_pc,
           upd_valid, upd_pc, upd_target, upd_taken,
    input  imemREN, imemaddr, inst_pc_if, pcp4_in, predicted_pc_in,
           if_id_enable, if_id_flush
  );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit saturating counters; combinational lookup, read-before-write update.
module branch_target_buffer
  import cpu_types_pkg::*;
#(
  parameter int BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] lk_pc,
  output logic        lk_taken,
  output logic [31:0] lk_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);

  btb_entry_t mem [BTB_ENTRIES];

  logic [29:0]          lk_word, upd_word;
  logic [IDX_W-1:0]     lk_idx, upd_idx;
  logic [TAG_W_MAX-1:0] lk_tag, upd_tag;
  btb_entry_t           lk_e, upd_e;
  logic                 lk_hit, upd_hit;

  assign lk_word  = 30'(lk_pc >> 2);
  assign upd_word = 30'(upd_pc >> 2);
  assign lk_idx   = lk_word[IDX_W-1:0];
  assign upd_idx  = upd_word[IDX_W-1:0];
  assign lk_tag   = TAG_W_MAX'(lk_word >> IDX_W);
  assign upd_tag  = TAG_W_MAX'(upd_word >> IDX_W);

  assign lk_e     = mem[lk_idx];
  assign upd_e    = mem[upd_idx];
  assign lk_hit   = lk_e.valid && (lk_e.tag == lk_tag);
  assign upd_hit  = upd_e.valid && (upd_e.tag == upd_tag);

  // Lookup reads the array before this edge's update lands, giving read-before-write for free.
  assign lk_taken  = lk_hit && predict_taken(lk_e.cnt);
  assign lk_target = lk_e.target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the BTB must start all-invalid with weak-not-taken counters, so every entry is reset explicitly.
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        mem[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: WNT};
      end
    end else if (upd_valid) begin
      if (upd_hit) begin
        mem[upd_idx].cnt <= cnt_step(upd_e.cnt, upd_taken);
        if (upd_taken) mem[upd_idx].target <= upd_target;
      end else if (upd_taken) begin
        mem[upd_idx] <= '{valid: 1'b1, tag: upd_tag, target: upd_target, cnt: WT};
      end
    end
  end

endmodule

// File: rtl/fetch_predict_unit.sv
// IF stage: PC register, sticky halt, next-PC selection and IF/ID latch control.
module fetch_predict_unit
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 16
) (
  input  logic                  CLK,
  input  logic                  nRST,
  fetch_predict_unit_if.master  bus
);

  logic [31:0] pc;
  logic [31:0] pcp4;
  logic        halted;
  logic        btb_taken;
  logic [31:0] btb_target;
  logic [31:0] predicted_pc;

  branch_target_buffer #(.BTB_ENTRIES(BTB_ENTRIES)) u_btb (
    .clk        (CLK),
    .rst_n      (nRST),
    .lk_pc      (pc),
    .lk_taken   (btb_taken),
    .lk_target  (btb_target),
    .upd_valid  (bus.upd_valid),
    .upd_pc     (bus.upd_pc),
    .upd_target (bus.upd_target),
    .upd_taken  (bus.upd_taken)
  );

  assign pcp4         = pc + 32'd4;
  assign predicted_pc = btb_taken ? btb_target : pcp4;

  assign bus.imemREN         = !halted;
  assign bus.imemaddr        = pc;
  assign bus.inst_pc_if      = pc;
  assign bus.pcp4_in         = pcp4;
  assign bus.predicted_pc_in = predicted_pc;
  assign bus.if_id_enable    = bus.ihit && !bus.stall && !halted && !bus.redirect;
  assign bus.if_id_flush     = bus.redirect;

  // Redirect outranks halt so a mispredict can recover a wrongly-halted wrong-path fetch.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc     <= RESET_PC;
      halted <= 1'b0;
    end else if (bus.redirect) begin
      pc     <= bus.redirect_pc;
      halted <= 1'b0;
    end else if (halted || bus.halt) begin
      halted <= 1'b1;
    end else if (!bus.stall && bus.ihit) begin
      pc <= predicted_pc;
    end
  end

endmodule
